// File: rtl/apb_cmd_master.sv
// APB requester driven by a simple valid/ready command channel.
// Each accepted command becomes one APB transfer (or an immediate error
// response when the byte address is not word aligned), and the result is
// returned on a valid/ready response channel. An optional wait-state
// limit aborts transfers whose slave never raises pready.
module apb_cmd_master #(
  parameter int DATA_WIDTH     = 32,
  parameter int ADDR_WIDTH     = 10,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic                  pclk_i,
  input  logic                  prst_n_i,
  // command side
  input  logic                  cmd_valid_i,
  output logic                  cmd_ready_o,
  input  logic                  cmd_write_i,
  input  logic [ADDR_WIDTH+1:0] cmd_addr_i,
  input  logic [DATA_WIDTH-1:0] cmd_wdata_i,
  input  logic [3:0]            cmd_strb_i,
  // response side
  output logic                  rsp_valid_o,
  input  logic                  rsp_ready_i,
  output logic [DATA_WIDTH-1:0] rsp_rdata_o,
  output logic                  rsp_err_o,
  output logic                  rsp_timeout_o,
  // APB requester
  output logic [ADDR_WIDTH+1:0] paddr_o,
  output logic                  psel_o,
  output logic                  penable_o,
  output logic                  pwrite_o,
  output logic [3:0]            pstrb_o,
  output logic [DATA_WIDTH-1:0] pwdata_o,
  input  logic                  pready_i,
  input  logic [DATA_WIDTH-1:0] prdata_i,
  input  logic                  pslverr_i
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_SETUP  = 2'd1,
    S_ACCESS = 2'd2,
    S_RESP   = 2'd3
  } state_e;

  // Counter value seen in the last permitted wait cycle; unused when the
  // limit is disabled.
  localparam bit          TimeoutEn = (TIMEOUT_CYCLES != 0);
  localparam logic [15:0] WaitLast  = TimeoutEn ? 16'(TIMEOUT_CYCLES - 1) : 16'd0;

  state_e                state_q;
  logic [ADDR_WIDTH+1:0] paddr_q;
  logic                  pwrite_q;
  logic [3:0]            pstrb_q;
  logic [DATA_WIDTH-1:0] pwdata_q;
  logic [15:0]           wait_q;
  logic [DATA_WIDTH-1:0] rsp_rdata_q;
  logic                  rsp_err_q;
  logic                  rsp_timeout_q;

  logic                  addr_aligned;
  logic                  timeout_hit;

  assign addr_aligned = (cmd_addr_i[1:0] == 2'b00);
  // Only meaningful in ACCESS; pready in the same cycle wins over the abort.
  assign timeout_hit  = TimeoutEn && (wait_q == WaitLast) && !pready_i;

  // Transfer sequencer: command capture, APB phases, wait counting and
  // response capture all live in this one registered process.
  // NOTE: every register here uses <= so all of them update together from
  // the values present before the clock edge; mixing in = would make the
  // result depend on statement order.
  always_ff @(posedge pclk_i or negedge prst_n_i) begin
    if (!prst_n_i) begin
      // NOTE: every register, datapath included, is cleared here because all
      // outputs must read zero while reset is held.
      state_q       <= S_IDLE;
      paddr_q       <= '0;
      pwrite_q      <= 1'b0;
      pstrb_q       <= 4'b0000;
      pwdata_q      <= '0;
      wait_q        <= 16'd0;
      rsp_rdata_q   <= '0;
      rsp_err_q     <= 1'b0;
      rsp_timeout_q <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (cmd_valid_i) begin
            if (addr_aligned) begin
              // APB-side fields only change for commands that reach the bus,
              // so a rejected command leaves the bus outputs untouched.
              paddr_q  <= cmd_addr_i;
              pwrite_q <= cmd_write_i;
              pwdata_q <= cmd_wdata_i;
              pstrb_q  <= cmd_write_i ? cmd_strb_i : 4'b0000;
              wait_q   <= 16'd0;
              state_q  <= S_SETUP;
            end else begin
              rsp_rdata_q   <= '0;
              rsp_err_q     <= 1'b1;
              rsp_timeout_q <= 1'b0;
              state_q       <= S_RESP;
            end
          end
        end

        S_SETUP: begin
          state_q <= S_ACCESS;
        end

        S_ACCESS: begin
          if (pready_i) begin
            rsp_rdata_q   <= pwrite_q ? '0 : prdata_i;
            rsp_err_q     <= pslverr_i;
            rsp_timeout_q <= 1'b0;
            state_q       <= S_RESP;
          end else if (timeout_hit) begin
            rsp_rdata_q   <= '0;
            rsp_err_q     <= 1'b1;
            rsp_timeout_q <= 1'b1;
            state_q       <= S_RESP;
          end else begin
            wait_q <= wait_q + 16'd1;
          end
        end

        S_RESP: begin
          if (rsp_ready_i) begin
            state_q <= S_IDLE;
          end
        end

        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  // Handshake and phase strobes decode the state register directly, so they
  // drop the instant reset is asserted.
  assign cmd_ready_o   = (state_q == S_IDLE);
  assign psel_o        = (state_q == S_SETUP) || (state_q == S_ACCESS);
  assign penable_o     = (state_q == S_ACCESS);
  assign rsp_valid_o   = (state_q == S_RESP);

  assign paddr_o       = paddr_q;
  assign pwrite_o      = pwrite_q;
  assign pstrb_o       = pstrb_q;
  assign pwdata_o      = pwdata_q;

  assign rsp_rdata_o   = rsp_rdata_q;
  assign rsp_err_o     = rsp_err_q;
  assign rsp_timeout_o = rsp_timeout_q;

endmodule
